// File: rtl/ccip_host_pkg.sv
// Shared widths, packed request/response layouts and MMIO length encoding
// for the host-side CCI-P responder.
package ccip_host_pkg;

  localparam int ADDR_W      = 42;
  localparam int TAG_W       = 16;
  localparam int CL_W        = 512;
  localparam int MMIO_ADDR_W = 16;
  localparam int MMIO_DATA_W = 64;
  localparam int TID_W       = 9;
  localparam int C0_HDR_W    = 27;

  typedef enum logic [1:0] {
    MMIO_LEN_4B  = 2'b00,
    MMIO_LEN_8B  = 2'b01,
    MMIO_LEN_64B = 2'b10
  } mmioLenT;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  mdata;
  } lineHdrT;

  typedef struct packed {
    lineHdrT         hdr;
    logic [CL_W-1:0] data;
  } wrReqT;

  typedef struct packed {
    logic              isWrite;
    logic [ADDR_W-1:0] addr;
    logic [CL_W-1:0]   data;
  } memReqT;

  typedef struct packed {
    logic                   isWrite;
    logic [MMIO_ADDR_W-1:0] addr;
    logic [MMIO_DATA_W-1:0] data;
    logic [TID_W-1:0]       tid;
  } mmioReqT;

  typedef struct packed {
    logic [MMIO_ADDR_W-1:0] addr;
    mmioLenT                length;
    logic [TID_W-1:0]       tid;
  } mmioHdrT;

  // Read-response header: tag in the low bits, upper bits unused by the AFU.
  function automatic logic [C0_HDR_W-1:0] rspHdr(input logic [TAG_W-1:0] mdata);
    return {{(C0_HDR_W-TAG_W){1'b0}}, mdata};
  endfunction

endpackage

// File: rtl/ccip_host_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; a push into a full FIFO
// is only accepted when a pop frees the slot in the same cycle.
module ccip_host_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             full;
  logic             empty;
  logic             doPush;
  logic             doPop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign doPop   = pop && !empty;
  assign doPush  = push && (!full || doPop);
  assign popData = mem[rdPtr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/ccip_host_responder.sv
// Host-end CCI-P model: queues AFU line requests toward a memory port,
// returns read data/write acks, and shares the c0 Rx channel with MMIO.
module ccip_host_responder
  import ccip_host_pkg::*;
#(
  parameter int REQ_DEPTH      = 16,
  parameter int ALM_FULL_SLACK = 4,
  parameter int MDATA_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 af2cp_c0_valid,
  input  logic [57:0]          af2cp_c0_hdr,
  input  logic                 af2cp_c1_valid,
  input  logic [57:0]          af2cp_c1_hdr,
  input  logic [511:0]         af2cp_c1_data,
  input  logic                 af2cp_c2_mmioRdValid,
  input  logic [72:0]          af2cp_c2_rsp,
  output logic [1:0]           cp2af_almfull,
  output logic                 cp2af_c0_rspValid,
  output logic                 cp2af_c0_mmioWrValid,
  output logic                 cp2af_c0_mmioRdValid,
  output logic [26:0]          cp2af_c0_hdr,
  output logic [511:0]         cp2af_c0_data,
  output logic                 cp2af_c1_rspValid,
  output logic [MDATA_W-1:0]   cp2af_c1_mdata,
  input  logic                 mmio_req_valid,
  input  logic [89:0]          mmio_req,
  output logic                 mmio_rsp_valid,
  output logic [72:0]          mmio_rsp,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [554:0]         mem_req,
  input  logic                 mem_rsp_valid,
  output logic                 mem_rsp_ready,
  input  logic [511:0]         mem_rsp_data
);

  localparam int CNT_W = $clog2(REQ_DEPTH) + 1;
  localparam logic [CNT_W-1:0] ALM_LEVEL  = CNT_W'(REQ_DEPTH - ALM_FULL_SLACK);
  localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(REQ_DEPTH);

  typedef enum logic {
    PICK_RD = 1'b0,
    PICK_WR = 1'b1
  } pickT;

  lineHdrT            c0Req;
  lineHdrT            rdHead;
  wrReqT              c1Req;
  wrReqT              wrHead;
  mmioReqT            mmioIn;
  memReqT             memReq;
  logic [MDATA_W-1:0] tagIn;
  logic [MDATA_W-1:0] tagHead;

  logic [CNT_W-1:0] rdCount;
  logic [CNT_W-1:0] wrCount;
  logic [CNT_W-1:0] tagCount;
  logic [CNT_W-1:0] rdCountNext;
  logic [CNT_W-1:0] wrCountNext;

  logic rdFull;
  logic wrFull;
  logic tagFull;
  logic tagEmpty;
  logic rdAccept;
  logic wrAccept;
  logic rdPop;
  logic wrPop;
  logic rdReady;
  logic wrReady;
  logic memReqFire;
  logic memRspFire;

  pickT rrPtr;
  pickT lockSel;
  pickT sel;
  logic lockValid;

  assign c0Req  = af2cp_c0_hdr;
  assign c1Req  = {af2cp_c1_hdr, af2cp_c1_data};
  assign mmioIn = mmio_req;
  assign tagIn  = MDATA_W'(rdHead.mdata);

  ccip_host_fifo #(.WIDTH($bits(lineHdrT)), .DEPTH(REQ_DEPTH)) rdq (
    .clk      (clk),
    .reset    (reset),
    .push     (af2cp_c0_valid),
    .pushData (c0Req),
    .pop      (rdPop),
    .popData  (rdHead),
    .count    (rdCount)
  );

  ccip_host_fifo #(.WIDTH($bits(wrReqT)), .DEPTH(REQ_DEPTH)) wrq (
    .clk      (clk),
    .reset    (reset),
    .push     (af2cp_c1_valid),
    .pushData (c1Req),
    .pop      (wrPop),
    .popData  (wrHead),
    .count    (wrCount)
  );

  // Tags of issued reads, popped in order as memory returns the data.
  ccip_host_fifo #(.WIDTH(MDATA_W), .DEPTH(REQ_DEPTH)) tagq (
    .clk      (clk),
    .reset    (reset),
    .push     (rdPop),
    .pushData (tagIn),
    .pop      (memRspFire),
    .popData  (tagHead),
    .count    (tagCount)
  );

  assign rdFull   = (rdCount == FULL_LEVEL);
  assign wrFull   = (wrCount == FULL_LEVEL);
  assign tagFull  = (tagCount == FULL_LEVEL);
  assign tagEmpty = (tagCount == '0);

  // While a request is stalled the locked choice is reused so mem_req stays put.
  always_comb begin
    rdReady = (rdCount != '0) && !tagFull;
    wrReady = (wrCount != '0);
    sel     = rrPtr;
    if (lockValid)                sel = lockSel;
    else if (rdReady && !wrReady) sel = PICK_RD;
    else if (wrReady && !rdReady) sel = PICK_WR;
    mem_req_valid = (sel == PICK_RD) ? rdReady : wrReady;
    if (sel == PICK_WR) begin
      memReq.isWrite = 1'b1;
      memReq.addr    = wrHead.hdr.addr;
      memReq.data    = wrHead.data;
    end else begin
      memReq.isWrite = 1'b0;
      memReq.addr    = rdHead.addr;
      memReq.data    = '0;
    end
  end

  assign mem_req    = memReq;
  assign memReqFire = mem_req_valid && mem_req_ready;
  assign rdPop      = memReqFire && (sel == PICK_RD);
  assign wrPop      = memReqFire && (sel == PICK_WR);

  // MMIO injection owns c0 Rx in its cycle, so memory read data waits.
  assign mem_rsp_ready = !mmio_req_valid && !tagEmpty;
  assign memRspFire    = mem_rsp_valid && mem_rsp_ready;

  assign rdAccept    = af2cp_c0_valid && (!rdFull || rdPop);
  assign wrAccept    = af2cp_c1_valid && (!wrFull || wrPop);
  assign rdCountNext = rdCount + CNT_W'(rdAccept) - CNT_W'(rdPop);
  assign wrCountNext = wrCount + CNT_W'(wrAccept) - CNT_W'(wrPop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rrPtr                <= PICK_RD;
      lockSel              <= PICK_RD;
      lockValid            <= 1'b0;
      cp2af_almfull        <= '0;
      cp2af_c0_rspValid    <= 1'b0;
      cp2af_c0_mmioWrValid <= 1'b0;
      cp2af_c0_mmioRdValid <= 1'b0;
      cp2af_c0_hdr         <= '0;
      cp2af_c0_data        <= '0;
      cp2af_c1_rspValid    <= 1'b0;
      cp2af_c1_mdata       <= '0;
      mmio_rsp_valid       <= 1'b0;
      mmio_rsp             <= '0;
    end else begin
      cp2af_almfull <= {wrCountNext >= ALM_LEVEL, rdCountNext >= ALM_LEVEL};
      lockValid     <= mem_req_valid && !mem_req_ready;
      lockSel       <= sel;
      if (memReqFire) rrPtr <= (sel == PICK_RD) ? PICK_WR : PICK_RD;

      cp2af_c1_rspValid <= wrPop;
      if (wrPop) cp2af_c1_mdata <= MDATA_W'(wrHead.hdr.mdata);

      cp2af_c0_rspValid    <= 1'b0;
      cp2af_c0_mmioWrValid <= 1'b0;
      cp2af_c0_mmioRdValid <= 1'b0;
      if (mmio_req_valid) begin
        cp2af_c0_mmioWrValid <= mmioIn.isWrite;
        cp2af_c0_mmioRdValid <= !mmioIn.isWrite;
        cp2af_c0_hdr         <= {mmioIn.addr, MMIO_LEN_8B, mmioIn.tid};
        cp2af_c0_data        <= CL_W'(mmioIn.data);
      end else if (memRspFire) begin
        cp2af_c0_rspValid <= 1'b1;
        cp2af_c0_hdr      <= rspHdr(TAG_W'(tagHead));
        cp2af_c0_data     <= mem_rsp_data;
      end

      mmio_rsp_valid <= af2cp_c2_mmioRdValid;
      if (af2cp_c2_mmioRdValid) mmio_rsp <= af2cp_c2_rsp;
    end
  end

  rdqOverflow: assert property (@(posedge clk) disable iff (!reset)
    !(af2cp_c0_valid && rdFull && !rdPop));
  wrqOverflow: assert property (@(posedge clk) disable iff (!reset)
    !(af2cp_c1_valid && wrFull && !wrPop));
  c0RxExclusive: assert property (@(posedge clk) disable iff (!reset)
    !(cp2af_c0_rspValid && (cp2af_c0_mmioWrValid || cp2af_c0_mmioRdValid)));

endmodule

// File: tb/tb_ccip_host_responder.sv
// Directed bench for ccip_host_responder: one task per scenario, each with
// its own hand-computed expectations.
module tb_ccip_host_responder;
  import ccip_host_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         af2cp_c0_valid = 1'b0;
  logic [57:0]  af2cp_c0_hdr = '0;
  logic         af2cp_c1_valid = 1'b0;
  logic [57:0]  af2cp_c1_hdr = '0;
  logic [511:0] af2cp_c1_data = '0;
  logic         af2cp_c2_mmioRdValid = 1'b0;
  logic [72:0]  af2cp_c2_rsp = '0;
  logic [1:0]   cp2af_almfull;
  logic         cp2af_c0_rspValid;
  logic         cp2af_c0_mmioWrValid;
  logic         cp2af_c0_mmioRdValid;
  logic [26:0]  cp2af_c0_hdr;
  logic [511:0] cp2af_c0_data;
  logic         cp2af_c1_rspValid;
  logic [15:0]  cp2af_c1_mdata;
  logic         mmio_req_valid = 1'b0;
  logic [89:0]  mmio_req = '0;
  logic         mmio_rsp_valid;
  logic [72:0]  mmio_rsp;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b1;
  logic [554:0] mem_req;
  logic         mem_rsp_valid = 1'b0;
  logic         mem_rsp_ready;
  logic [511:0] mem_rsp_data = '0;

  int compared = 0;
  int mismatched = 0;

  logic [554:0] memHsQ[$];
  logic [15:0]  ackQ[$];
  logic [527:0] rspQ[$];

  always #5 clk = ~clk;

  ccip_host_responder dut (
    .clk                  (clk),
    .reset                (reset),
    .af2cp_c0_valid       (af2cp_c0_valid),
    .af2cp_c0_hdr         (af2cp_c0_hdr),
    .af2cp_c1_valid       (af2cp_c1_valid),
    .af2cp_c1_hdr         (af2cp_c1_hdr),
    .af2cp_c1_data        (af2cp_c1_data),
    .af2cp_c2_mmioRdValid (af2cp_c2_mmioRdValid),
    .af2cp_c2_rsp         (af2cp_c2_rsp),
    .cp2af_almfull        (cp2af_almfull),
    .cp2af_c0_rspValid    (cp2af_c0_rspValid),
    .cp2af_c0_mmioWrValid (cp2af_c0_mmioWrValid),
    .cp2af_c0_mmioRdValid (cp2af_c0_mmioRdValid),
    .cp2af_c0_hdr         (cp2af_c0_hdr),
    .cp2af_c0_data        (cp2af_c0_data),
    .cp2af_c1_rspValid    (cp2af_c1_rspValid),
    .cp2af_c1_mdata       (cp2af_c1_mdata),
    .mmio_req_valid       (mmio_req_valid),
    .mmio_req             (mmio_req),
    .mmio_rsp_valid       (mmio_rsp_valid),
    .mmio_rsp             (mmio_rsp),
    .mem_req_valid        (mem_req_valid),
    .mem_req_ready        (mem_req_ready),
    .mem_req              (mem_req),
    .mem_rsp_valid        (mem_rsp_valid),
    .mem_rsp_ready        (mem_rsp_ready),
    .mem_rsp_data         (mem_rsp_data)
  );

  // Log handshakes, acks and read responses for the ordering checks.
  always @(negedge clk) begin
    if (mem_req_valid && mem_req_ready) memHsQ.push_back(mem_req);
    if (cp2af_c1_rspValid) ackQ.push_back(cp2af_c1_mdata);
    if (cp2af_c0_rspValid) rspQ.push_back({cp2af_c0_hdr[15:0], cp2af_c0_data});
  end

  function automatic logic [511:0] wLine(input int i);
    return {16{32'h5A00_0000 + 32'(i)}};
  endfunction

  function automatic logic [511:0] rLine(input int i);
    return {16{32'hC0DE_0000 + 32'(i)}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    compared++; if (cp2af_almfull !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_almfull: got %b want 00", cp2af_almfull); end
    compared++; if (cp2af_c0_rspValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rspValid: got %b want 0", cp2af_c0_rspValid); end
    compared++; if (cp2af_c0_mmioWrValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mmioWr: got %b want 0", cp2af_c0_mmioWrValid); end
    compared++; if (cp2af_c0_mmioRdValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mmioRd: got %b want 0", cp2af_c0_mmioRdValid); end
    compared++; if (cp2af_c1_rspValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_c1Ack: got %b want 0", cp2af_c1_rspValid); end
    compared++; if (mem_req_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_memReqValid: got %b want 0", mem_req_valid); end
    compared++; if (mmio_rsp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mmioRspValid: got %b want 0", mmio_rsp_valid); end
    compared++; if (mem_rsp_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_memRspReady: got %b want 0", mem_rsp_ready); end
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_read();
    logic [511:0] line;
    line = {16{32'hDEAD_BEEF}};
    mem_req_ready  = 1'b1;
    af2cp_c0_valid = 1'b1;
    af2cp_c0_hdr   = {42'h100, 16'h00A5};
    tick();
    af2cp_c0_valid = 1'b0;
    @(negedge clk);
    compared++; if (mem_req_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL read_memReqValid: got %b want 1", mem_req_valid); end
    compared++; if (mem_req !== {1'b0, 42'h100, 512'h0}) begin mismatched++; $display("[TB] FAIL read_memReq: got rw/addr %h want 0/100", mem_req[554:512]); end
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = line;
    @(negedge clk);
    compared++; if (mem_rsp_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL read_memRspReady: got %b want 1", mem_rsp_ready); end
    compared++; if (mem_req_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL read_reqDrained: got %b want 0", mem_req_valid); end
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    compared++; if (cp2af_c0_rspValid !== 1'b1) begin mismatched++; $display("[TB] FAIL read_rspValid: got %b want 1", cp2af_c0_rspValid); end
    compared++; if (cp2af_c0_hdr !== {11'h0, 16'h00A5}) begin mismatched++; $display("[TB] FAIL read_rspHdr: got %h want 00a5", cp2af_c0_hdr); end
    compared++; if (cp2af_c0_data !== line) begin mismatched++; $display("[TB] FAIL read_rspData: got low %h want deadbeef", cp2af_c0_data[31:0]); end
    tick();
    @(negedge clk);
    compared++; if (cp2af_c0_rspValid !== 1'b0) begin mismatched++; $display("[TB] FAIL read_rspOnce: got %b want 0", cp2af_c0_rspValid); end
    tick();
  endtask

  task automatic test_write_ack();
    af2cp_c1_valid = 1'b1;
    af2cp_c1_hdr   = {42'h300, 16'h0077};
    af2cp_c1_data  = wLine(7);
    tick();
    af2cp_c1_valid = 1'b0;
    @(negedge clk);
    compared++; if (mem_req !== {1'b1, 42'h300, wLine(7)} || mem_req_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL write_memReq: got valid %b rw/addr %h want 1 and 1/300", mem_req_valid, mem_req[554:512]); end
    compared++; if (cp2af_c1_rspValid !== 1'b0) begin mismatched++; $display("[TB] FAIL write_ackEarly: got %b want 0", cp2af_c1_rspValid); end
    tick();
    @(negedge clk);
    compared++; if (cp2af_c1_rspValid !== 1'b1 || cp2af_c1_mdata !== 16'h0077) begin mismatched++; $display("[TB] FAIL write_ack: got %b/%h want 1/0077", cp2af_c1_rspValid, cp2af_c1_mdata); end
    tick();
    @(negedge clk);
    compared++; if (cp2af_c1_rspValid !== 1'b0) begin mismatched++; $display("[TB] FAIL write_ackOnce: got %b want 0", cp2af_c1_rspValid); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [554:0] exp;
    logic [554:0] got;
    memHsQ.delete(); ackQ.delete(); rspQ.delete();
    mem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      af2cp_c0_valid = 1'b1;
      af2cp_c0_hdr   = {42'h1000 + 42'(i), 16'h0010 + 16'(i)};
      af2cp_c1_valid = 1'b1;
      af2cp_c1_hdr   = {42'h2000 + 42'(i), 16'h0020 + 16'(i)};
      af2cp_c1_data  = wLine(i);
      tick();
    end
    af2cp_c0_valid = 1'b0;
    af2cp_c1_valid = 1'b0;
    repeat (7) tick();
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 1) exp = {1'b1, 42'h2000 + 42'(k / 2), wLine(k / 2)};
      else            exp = {1'b0, 42'h1000 + 42'(k / 2), 512'h0};
      got = (k < memHsQ.size()) ? memHsQ[k] : 'x;
      compared++; if (got !== exp) begin mismatched++; $display("[TB] FAIL b2b_issue%0d: got rw/addr %h want %h", k, got[554:512], exp[554:512]); end
    end
    for (int i = 0; i < 4; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = rLine(i);
      tick();
    end
    mem_rsp_valid = 1'b0;
    repeat (2) tick();
    compared++; if (ackQ.size() != 4) begin mismatched++; $display("[TB] FAIL b2b_ackCount: got %0d want 4", ackQ.size()); end
    for (int i = 0; i < 4; i++) begin
      compared++; if (i >= ackQ.size() || ackQ[i] !== 16'h0020 + 16'(i)) begin mismatched++; $display("[TB] FAIL b2b_ack%0d: got %h want %h", i, (i < ackQ.size()) ? ackQ[i] : 16'hxxxx, 16'h0020 + 16'(i)); end
    end
    for (int i = 0; i < 4; i++) begin
      compared++; if (i >= rspQ.size() || rspQ[i] !== {16'h0010 + 16'(i), rLine(i)}) begin mismatched++; $display("[TB] FAIL b2b_rsp%0d: got mdata %h want %h", i, (i < rspQ.size()) ? rspQ[i][527:512] : 16'hxxxx, 16'h0010 + 16'(i)); end
    end
  endtask

  task automatic test_almfull();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      af2cp_c0_valid = 1'b1;
      af2cp_c0_hdr   = {42'h4000 + 42'(i), 16'h0030 + 16'(i)};
      tick();
      if (i == 10) begin
        compared++; if (cp2af_almfull !== 2'b00) begin mismatched++; $display("[TB] FAIL almfull_at11: got %b want 00", cp2af_almfull); end
      end
    end
    af2cp_c0_valid = 1'b0;
    compared++; if (cp2af_almfull !== 2'b01) begin mismatched++; $display("[TB] FAIL almfull_at12: got %b want 01", cp2af_almfull); end
    @(negedge clk);
    compared++; if (mem_req_valid !== 1'b1 || mem_req !== {1'b0, 42'h4000, 512'h0}) begin mismatched++; $display("[TB] FAIL almfull_stall: got valid %b rw/addr %h want 1 and 0/4000", mem_req_valid, mem_req[554:512]); end
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    compared++; if (cp2af_almfull !== 2'b00) begin mismatched++; $display("[TB] FAIL almfull_drain: got %b want 00", cp2af_almfull); end
    mem_req_ready = 1'b1;
    repeat (12) tick();
    rspQ.delete();
    for (int i = 0; i < 12; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = rLine(20 + i);
      tick();
    end
    mem_rsp_valid = 1'b0;
    repeat (2) tick();
    compared++; if (rspQ.size() != 12) begin mismatched++; $display("[TB] FAIL almfull_rspCount: got %0d want 12", rspQ.size()); end
    compared++; if (rspQ.size() < 12 || rspQ[11] !== {16'h003B, rLine(31)}) begin mismatched++; $display("[TB] FAIL almfull_lastRsp: got mdata %h want 003b", (rspQ.size() >= 12) ? rspQ[11][527:512] : 16'hxxxx); end
  endtask

  task automatic test_mmio_collision();
    logic [511:0] line;
    line = rLine(99);
    mem_req_ready  = 1'b1;
    af2cp_c0_valid = 1'b1;
    af2cp_c0_hdr   = {42'h500, 16'h0042};
    tick();
    af2cp_c0_valid = 1'b0;
    tick();
    mem_rsp_valid  = 1'b1;
    mem_rsp_data   = line;
    mmio_req_valid = 1'b1;
    mmio_req       = {1'b1, 16'h0020, 64'h1234, 9'h000};
    @(negedge clk);
    compared++; if (mem_rsp_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL coll_rspBlocked: got %b want 0", mem_rsp_ready); end
    tick();
    mmio_req_valid = 1'b0;
    @(negedge clk);
    compared++; if (cp2af_c0_mmioWrValid !== 1'b1 || cp2af_c0_rspValid !== 1'b0) begin mismatched++; $display("[TB] FAIL coll_mmioFirst: got wr %b rsp %b want 1 0", cp2af_c0_mmioWrValid, cp2af_c0_rspValid); end
    compared++; if (cp2af_c0_hdr !== {16'h0020, 2'b01, 9'h000}) begin mismatched++; $display("[TB] FAIL coll_mmioHdr: got %h want %h", cp2af_c0_hdr, {16'h0020, 2'b01, 9'h000}); end
    compared++; if (cp2af_c0_data !== {448'h0, 64'h1234}) begin mismatched++; $display("[TB] FAIL coll_mmioData: got low %h want 1234", cp2af_c0_data[63:0]); end
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    compared++; if (cp2af_c0_rspValid !== 1'b1 || cp2af_c0_mmioWrValid !== 1'b0) begin mismatched++; $display("[TB] FAIL coll_rspSecond: got rsp %b wr %b want 1 0", cp2af_c0_rspValid, cp2af_c0_mmioWrValid); end
    compared++; if (cp2af_c0_hdr !== {11'h0, 16'h0042} || cp2af_c0_data !== line) begin mismatched++; $display("[TB] FAIL coll_rspContent: got hdr %h want 0042", cp2af_c0_hdr); end
    tick();
  endtask

  task automatic test_mmio_read();
    mmio_req_valid = 1'b1;
    mmio_req       = {1'b0, 16'h0040, 64'h0, 9'h005};
    tick();
    mmio_req_valid = 1'b0;
    @(negedge clk);
    compared++; if (cp2af_c0_mmioRdValid !== 1'b1 || cp2af_c0_mmioWrValid !== 1'b0) begin mismatched++; $display("[TB] FAIL mmioRd_valid: got rd %b wr %b want 1 0", cp2af_c0_mmioRdValid, cp2af_c0_mmioWrValid); end
    compared++; if (cp2af_c0_hdr !== {16'h0040, 2'b01, 9'h005}) begin mismatched++; $display("[TB] FAIL mmioRd_hdr: got %h want %h", cp2af_c0_hdr, {16'h0040, 2'b01, 9'h005}); end
    tick();
    af2cp_c2_mmioRdValid = 1'b1;
    af2cp_c2_rsp         = {9'h005, 64'hCAFE};
    tick();
    af2cp_c2_mmioRdValid = 1'b0;
    @(negedge clk);
    compared++; if (mmio_rsp_valid !== 1'b1 || mmio_rsp !== {9'h005, 64'hCAFE}) begin mismatched++; $display("[TB] FAIL mmioRd_rsp: got %b/%h want 1/%h", mmio_rsp_valid, mmio_rsp, {9'h005, 64'hCAFE}); end
    tick();
    @(negedge clk);
    compared++; if (mmio_rsp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mmioRd_rspOnce: got %b want 0", mmio_rsp_valid); end
    tick();
  endtask

  task automatic test_reset_midop();
    mem_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      af2cp_c0_valid = 1'b1;
      af2cp_c0_hdr   = {42'h6000 + 42'(i), 16'h0060 + 16'(i)};
      tick();
    end
    af2cp_c0_hdr = {42'h6003, 16'h0063};
    tick();
    af2cp_c0_valid = 1'b0;
    mem_req_ready  = 1'b0;
    @(negedge clk);
    compared++; if (mem_req_valid !== 1'b1 || mem_rsp_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL midop_pending: got req %b rspRdy %b want 1 1", mem_req_valid, mem_rsp_ready); end
    #1 reset = 1'b0;
    #1;
    compared++; if (mem_req_valid !== 1'b0 || mem_rsp_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL midop_asyncClear: got req %b rspRdy %b want 0 0", mem_req_valid, mem_rsp_ready); end
    compared++; if (cp2af_almfull !== 2'b00 || cp2af_c0_rspValid !== 1'b0 || cp2af_c1_rspValid !== 1'b0) begin mismatched++; $display("[TB] FAIL midop_outputs: got af %b rsp %b ack %b want 00 0 0", cp2af_almfull, cp2af_c0_rspValid, cp2af_c1_rspValid); end
    repeat (2) tick();
    reset = 1'b1;
    mem_req_ready = 1'b1;
    rspQ.delete();
    for (int i = 0; i < 3; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = rLine(40 + i);
      tick();
    end
    mem_rsp_valid = 1'b0;
    repeat (2) tick();
    compared++; if (rspQ.size() != 0) begin mismatched++; $display("[TB] FAIL midop_noRsp: got %0d responses want 0", rspQ.size()); end
    compared++; if (mem_req_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midop_queuesEmpty: got %b want 0", mem_req_valid); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_ack();
    test_back_to_back();
    test_almfull();
    test_mmio_collision();
    test_mmio_read();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ccip_host_responder.md
Name: ccip_host_responder

Overview:
- Host-side (platform-end) model of the CCI-P link, driving the Rx side and consuming the Tx side that the AFU presents.
- Services AFU cache-line reads (c0) and writes (c1) against an external host-memory port.
- Injects testbench MMIO reads/writes onto c0 and returns AFU MMIO read data (c2) to the testbench.
- Generates c0/c1 TxAlmFull from internal queue occupancy.

Parameters:
REQ_DEPTH, 16, entries in each of the read and write request FIFOs (power of 2, ≥4).
ALM_FULL_SLACK, 4, free entries remaining at which almost-full asserts.
MDATA_W, 16, request tag width.

Ports:
clk  in  1  clock, all logic rising-edge.
reset  in  1  asynchronous, active-low; 0 = in reset.
af2cp_c0_valid  in  1  AFU read-line request.
af2cp_c0_hdr  in  58  {address[41:0], mdata[15:0]}.
af2cp_c1_valid  in  1  AFU write-line request.
af2cp_c1_hdr  in  58  {address[41:0], mdata[15:0]}.
af2cp_c1_data  in  512  write line.
af2cp_c2_mmioRdValid  in  1  AFU MMIO read response.
af2cp_c2_rsp  in  73  {tid[8:0], data[63:0]}.
cp2af_almfull  out  2  {c1TxAlmFull, c0TxAlmFull}.
cp2af_c0_rspValid  out  1  read response.
cp2af_c0_mmioWrValid  out  1  MMIO write to AFU.
cp2af_c0_mmioRdValid  out  1  MMIO read to AFU.
cp2af_c0_hdr  out  27  rsp: {11'b0, mdata}; MMIO: {address[15:0], length[1:0], tid[8:0]}.
cp2af_c0_data  out  512  read line, or MMIO write data in [63:0].
cp2af_c1_rspValid  out  1  write ack.
cp2af_c1_mdata  out  16  write-ack tag.
mmio_req_valid  in  1  testbench MMIO request, single-cycle pulse, always accepted.
mmio_req  in  90  {is_write, address[15:0], data[63:0], tid[8:0]}.
mmio_rsp_valid  out  1  MMIO read data returned.
mmio_rsp  out  73  {tid, data}.
mem_req_valid  out  1  memory request.
mem_req_ready  in  1  memory accepts.
mem_req  out  555  {rw(1=write), address[41:0], data[511:0]}.
mem_rsp_valid  in  1  read data, returned in order.
mem_rsp_ready  out  1  responder accepts read data.
mem_rsp_data  in  512  read line.

Behaviour:
- Reset: all valids, cp2af_almfull, FIFO counts and the arbiter pointer = 0; the read-tag FIFO is emptied.
- Requests:
  - c0 request pushes {addr, mdata} into RDQ; c1 request pushes {addr, mdata, data} into WRQ.
  - A push into a full queue is a protocol error: drop it and fire an assertion.
- almfull[n]: registered; 1 when the queue count ≥ REQ_DEPTH-ALM_FULL_SLACK on the next cycle.
- Arbiter:
  - Round-robin between non-empty RDQ and WRQ; the pointer advances only on mem handshake.
  - mem_req holds stable while valid && !ready.
  - A read may not issue if the read-tag FIFO (depth REQ_DEPTH) is full.
- Read issue pushes mdata to the tag FIFO. Read completion = mem_rsp handshake, which pops the tag.
  - Registered output next cycle: rspValid=1, hdr mdata = popped tag, data = mem_rsp_data.
- Write issue (handshake) → cp2af_c1_rspValid=1 with that mdata next cycle. Exactly one ack per write.
- c0 Rx sharing:
  - mmio_req_valid has priority: mem_rsp_ready=0 in that cycle.
  - Next cycle drives mmioWrValid or mmioRdValid with hdr {address, length=2'b01, tid} and data[63:0].
  - Read response and MMIO are never both valid in one cycle.
- af2cp_c2_mmioRdValid → mmio_rsp_valid=1 with rsp next cycle.
- Latency (no backpressure):
  - c0 request to mem_req_valid: 1 cycle.
  - mem_rsp to rspValid: 1 cycle.
  - Write request to ack: 2 cycles.
- Simultaneous push and pop on one queue: count unchanged.
- Reset mid-operation drops in-flight state; no responses are emitted after reset.

Decomposition:
- Shared package ccip_host_pkg: field widths (address 42, mdata 16, clData 512, MMIO address 16, tid 9), packed request/response structs, length encoding.
- One natural sub-module: ccip_host_fifo, a parameterized sync FIFO with count output. Instantiate it three times: RDQ, WRQ, tag FIFO.

Test Plan:
- Read: c0 addr 0x100 mdata 0x00A5, memory returns 0xDEAD.. → rspValid with mdata 0x00A5 and data 0xDEAD.., 2 cycles after the mem handshake path.
- Interleave: 4 reads, 4 writes back-to-back, mem_req_ready=1 → issue order R,W,R,W,...; 4 c1 acks with matching mdata; read responses in issue order.
- Almost-full: mem_req_ready=0, push 12 reads → almfull[0]=1 the cycle after the 12th push; drain one → deasserts.
- MMIO collision: mem_rsp_valid and mmio_req_valid (write, addr 0x20, data 0x1234) in the same cycle → mmioWrValid first, rspValid one cycle later, data intact.
- MMIO read: mmio read tid 0x05; AFU returns c2 data 0xCAFE tid 0x05 → mmio_rsp = {0x05, 0xCAFE}.
- Reset: assert reset with 3 reads outstanding → all outputs 0 asynchronously, and no rspValid after release.
